dm_cache_ctrl: RTL
==================

Name: dm_cache_ctrl

Overview:
Parametrised direct-mapped read cache with a real miss state machine, a request/acknowledge refill interface to backing memory, and saturating hit, miss and access statistics. It sits between the CPU load path and word-organised main memory. CPU requests are held until a one-cycle response pulse; misses stall while a full line is fetched.

Parameters:
ADDR_W, 15, CPU word-address width
WORD_W, 32, data word width
OFFSET_W, 2, log2(words per line)
INDEX_W, 10, log2(line count)
CNT_W, 16, statistics counter width
(derived) TAG_W = ADDR_W-INDEX_W-OFFSET_W; LINE_W = WORD_W<<OFFSET_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
cpu_req  in  1  request; sampled only while cpu_ready=1
cpu_addr  in  ADDR_W  word address; sampled with cpu_req
cpu_ready  out  1  controller idle, can accept a request
rsp_valid  out  1  one-cycle pulse, rsp_data valid
rsp_data  out  WORD_W  returned word (registered)
rsp_hit  out  1  with rsp_valid: 1 = served without refill
mem_req  out  1  refill request, held until mem_ack
mem_addr  out  ADDR_W  line base address (offset bits zero), stable while mem_req=1
mem_ack  in  1  refill data valid this cycle
mem_data  in  LINE_W  line data; word 0 in LSBs
access_cnt  out  CNT_W  accepted requests
hit_cnt  out  CNT_W  requests served as hits
miss_cnt  out  CNT_W  refills performed

Behaviour:
- Address split: offset=[OFFSET_W-1:0], index=next INDEX_W bits, tag=top TAG_W bits.
- Storage: data array (no reset), tag array (no reset), valid vector of 2^INDEX_W bits (reset to 0).
- Reset (rst=0, async): state IDLE, valid vector all 0, cpu_ready=1, rsp_valid=0, rsp_hit=0, rsp_data=0, mem_req=0, mem_addr=0, all counters 0. Reset mid-refill drops the refill; a late mem_ack after reset is ignored in IDLE.
- FSM states: IDLE, COMPARE, REFILL (plus FLUSH, optional).
- IDLE: cpu_ready=1. If cpu_req=1: latch cpu_addr, access_cnt++, go COMPARE.
- COMPARE: hit = valid[idx] && tag_arr[idx]==tag.
  - Hit: next edge rsp_valid=1, rsp_data=selected word, rsp_hit = not-refilled flag; hit_cnt++ only if not refilled; go IDLE.
  - Miss: next edge mem_req=1, mem_addr={tag,idx,0}, miss_cnt++, go REFILL.
- REFILL: wait for mem_ack. On mem_ack edge: write line, set tag, set valid[idx]=1, set refilled flag, clear mem_req, go COMPARE (guaranteed hit).
- Refilled flag: cleared on request acceptance.
- Latency: hit, req accepted at edge N, rsp_valid high cycle N+2. Miss: mem_req high from N+2; ack at edge M gives rsp_valid at M+2.
- cpu_ready is high in the same cycle as rsp_valid, so back-to-back requests are allowed.
- rsp_valid is low in every other cycle; rsp_data holds its last value.
- Counters saturate at all-ones and do not wrap.
- mem_ack outside REFILL is ignored. cpu_req outside IDLE is ignored, not queued.
- Conflict: a line replaced by a same-index, different-tag address evicts the old tag unconditionally.

Optional Feature:
Macro CACHE_FLUSH_EN.
- Defined:
  - Adds input flush (1) and output flush_done (1, reset 0).
  - In IDLE, flush=1 has priority over cpu_req.
  - Enters FLUSH and clears valid[i] for i=0..2^INDEX_W-1, one index per cycle; cpu_ready=0 throughout.
  - After the last index: flush_done pulses one cycle, return to IDLE.
  - Counters are unaffected.
- Undefined: no flush ports, no FLUSH state; valid bits are cleared only by reset.

Test Plan:
- Reset then read addr 0x0005 -> mem_req with mem_addr 0x0004. Ack with mem_data words {W3..W0}={0xD,0xC,0xB,0xA} -> rsp_data 0xB, rsp_hit 0; miss_cnt=1, access_cnt=1, hit_cnt=0.
- Then read 0x0006 -> no mem_req; rsp_valid exactly 2 cycles after acceptance; rsp_data 0xC, rsp_hit 1; hit_cnt=1.
- Conflict: read 0x1004 (same index 1, tag 1) -> refill with mem_addr 0x1004. Re-read 0x0004 -> misses again; miss_cnt=3.
- Delay mem_ack 7 cycles with cpu_req toggling -> mem_req/mem_addr stable, cpu_ready 0, no extra access_cnt increments.
- Assert rst low during REFILL -> all outputs at reset values immediately. A later mem_ack is ignored. Read 0x0005 -> miss.
- With CNT_W=4: issue 20 hits -> hit_cnt holds 15. With CACHE_FLUSH_EN and INDEX_W=10: flush -> flush_done 1024 cycles later; next read of a cached address misses.

Source files
------------

// File: rtl/dm_cache_ctrl_if.sv
// CPU load-path and refill bus for dm_cache_ctrl.
// master: the CPU/memory side that drives requests and refill data.
// slave : the cache controller.
interface dm_cache_ctrl_if #(
    parameter int ADDR_W   = 15,
    parameter int WORD_W   = 32,
    parameter int OFFSET_W = 2
);
    localparam int LINE_W = WORD_W << OFFSET_W;

    logic              cpu_req;
    logic [ADDR_W-1:0] cpu_addr;
    logic              cpu_ready;
    logic              rsp_valid;
    logic [WORD_W-1:0] rsp_data;
    logic              rsp_hit;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [LINE_W-1:0] mem_data;

    modport master (
        output cpu_req, cpu_addr, mem_ack, mem_data,
        input  cpu_ready, rsp_valid, rsp_data, rsp_hit, mem_req, mem_addr
    );

    modport slave (
        input  cpu_req, cpu_addr, mem_ack, mem_data,
        output cpu_ready, rsp_valid, rsp_data, rsp_hit, mem_req, mem_addr
    );
endinterface

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped read cache controller with line refill over a req/ack bus
// and saturating access/hit/miss statistics.
// Optional feature macro: CACHE_FLUSH_EN adds flush/flush_done and a FLUSH
// state that clears one valid bit per cycle.
module dm_cache_ctrl #(
    parameter int ADDR_W   = 15,
    parameter int WORD_W   = 32,
    parameter int OFFSET_W = 2,
    parameter int INDEX_W  = 10,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    dm_cache_ctrl_if.slave   bus,
    output logic [CNT_W-1:0] access_cnt,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
`ifdef CACHE_FLUSH_EN
    ,
    input  logic             flush,
    output logic             flush_done
`endif
);
    localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
    localparam int WORDS = 1 << OFFSET_W;
    localparam int LINES = 1 << INDEX_W;

`ifdef CACHE_FLUSH_EN
    typedef enum logic [1:0] {IDLE, COMPARE, REFILL, FLUSH} state_t;
`else
    typedef enum logic [1:0] {IDLE, COMPARE, REFILL} state_t;
`endif

    state_t                        state;
    logic [ADDR_W-1:0]             addrQ;
    logic                          refilled;
    logic [LINES-1:0]              valid;
    logic [WORDS-1:0][WORD_W-1:0]  dataArr [LINES];
    logic [TAG_W-1:0]              tagArr  [LINES];
`ifdef CACHE_FLUSH_EN
    logic [INDEX_W-1:0]            flushIdx;
`endif

    logic [TAG_W-1:0]    tagQ;
    logic [INDEX_W-1:0]  idxQ;
    logic [OFFSET_W-1:0] offQ;
    logic                hit;

    assign tagQ = addrQ[ADDR_W-1 -: TAG_W];
    assign idxQ = addrQ[OFFSET_W +: INDEX_W];
    assign offQ = addrQ[OFFSET_W-1:0];
    // Invalid lines never hit, so uninitialised tags are harmless.
    assign hit  = valid[idxQ] && (tagArr[idxQ] == tagQ);

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    // Control FSM, valid bits, registered bus outputs and statistics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= IDLE;
            addrQ         <= '0;
            refilled      <= 1'b0;
            valid         <= '0;
            bus.cpu_ready <= 1'b1;
            bus.rsp_valid <= 1'b0;
            bus.rsp_hit   <= 1'b0;
            bus.rsp_data  <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_addr  <= '0;
            access_cnt    <= '0;
            hit_cnt       <= '0;
            miss_cnt      <= '0;
`ifdef CACHE_FLUSH_EN
            flushIdx      <= '0;
            flush_done    <= 1'b0;
`endif
        end else begin
            bus.rsp_valid <= 1'b0;
`ifdef CACHE_FLUSH_EN
            flush_done    <= 1'b0;
`endif
            case (state)
                IDLE: begin
`ifdef CACHE_FLUSH_EN
                    if (flush) begin
                        state         <= FLUSH;
                        flushIdx      <= '0;
                        bus.cpu_ready <= 1'b0;
                    end else
`endif
                    if (bus.cpu_req) begin
                        addrQ         <= bus.cpu_addr;
                        refilled      <= 1'b0;
                        access_cnt    <= satInc(access_cnt);
                        bus.cpu_ready <= 1'b0;
                        state         <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_data  <= dataArr[idxQ][offQ];
                        bus.rsp_hit   <= !refilled;
                        if (!refilled)
                            hit_cnt <= satInc(hit_cnt);
                        bus.cpu_ready <= 1'b1;
                        state         <= IDLE;
                    end else begin
                        bus.mem_req  <= 1'b1;
                        bus.mem_addr <= {addrQ[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
                        miss_cnt     <= satInc(miss_cnt);
                        state        <= REFILL;
                    end
                end
                REFILL: begin
                    if (bus.mem_ack) begin
                        valid[idxQ] <= 1'b1;
                        refilled    <= 1'b1;
                        bus.mem_req <= 1'b0;
                        state       <= COMPARE;
                    end
                end
`ifdef CACHE_FLUSH_EN
                FLUSH: begin
                    valid[flushIdx] <= 1'b0;
                    flushIdx        <= flushIdx + INDEX_W'(1);
                    if (flushIdx == '1) begin
                        flush_done    <= 1'b1;
                        bus.cpu_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    // Line and tag storage, written when a refill is acknowledged.
    always_ff @(posedge clk) begin
        if (state == REFILL && bus.mem_ack) begin
            dataArr[idxQ] <= bus.mem_data;
            tagArr[idxQ]  <= tagQ;
        end
    end
endmodule
